dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single data_memory port between two requesters: port 0 is the core LSU and port 1 is the debug/loader.
//   - Each request is a valid/ready handshake; arbitration is round-robin.
//   - Each granted request is sequenced as one registered ACCESS cycle, then a one-cycle response pulse.
//   - Rejects misaligned or illegal-size accesses with an error response; these never touch memory.
//   - Sits between the requesters and the data_memory instance (negedge write, combinational read).
// PARAMETERS
//   DATA_WIDTH  32  data bus width
//   ADDR_WIDTH  32  byte address width
// PORTS
//   clk           in   1           system clock; all state changes on posedge
//   rstn          in   1           reset, asynchronous, active-low
//   req_valid_i   in   2           per-port request valid ([0]=LSU, [1]=loader)
//   req_ready_o   out  2           per-port accept; handshake when valid&ready at posedge
//   req_write_i   in   2           1=store, 0=load
//   req_mask_i    in   2x2         maskmode per port: 00 byte, 01 half, 10 word, 11 illegal
//   req_sext_i    in   2           0=sign-extend, 1=zero-extend (loads only)
//   req_addr_i    in   2xADDR      byte address per port
//   req_wdata_i   in   2xDATA      store data per port
//   rsp_valid_o   out  2           one-cycle response pulse to the owning port
//   rsp_err_o     out  1           response is an error (qualified by rsp_valid_o)
//   rsp_rdata_o   out  DATA        registered load data; 0 for stores and errors
//   mem_write     out  1           to data_memory
//   mem_read      out  1           to data_memory
//   maskmode      out  2           to data_memory
//   sext          out  1           to data_memory
//   address       out  ADDR        to data_memory
//   write_data    out  DATA        to data_memory
//   read_data     in   DATA        from data_memory (combinational)
// BEHAVIOUR
//   Reset (async, rstn=0) forces immediately:
//   - state=IDLE, rr pointer=0 (port 0 favoured), latched request regs=0.
//   - All outputs 0; mem strobes drop at once, so a store is dropped if reset asserts before its negedge.
//   FSM (2 states):
//   - IDLE: req_ready_o granted per rr rule below.
//     - On handshake: latch port id, write, mask, sext, addr, wdata; ->ACCESS.
//     - Else stay in IDLE.
//   - ACCESS: exactly one cycle; req_ready_o=00.
//     - If the latched request is legal: drive mem_* from the latched regs (registered, glitch-free).
//       data_memory writes at the mid-cycle negedge.
//     - At the next posedge: rsp_rdata_o<=read_data (loads) or 0 (stores); rsp_valid_o[id]<=1; ->IDLE.
//   - rsp_valid_o is high for exactly the first IDLE cycle after ACCESS.
//   Grant rule in IDLE:
//   - Only valid requesters can win.
//   - Both valid: the port != last granted wins; pointer updates on every handshake.
//   Latency and throughput:
//   - Handshake edge E0 -> response visible after edge E0+1.
//   - Peak throughput is one access per 2 cycles.
//   - A new handshake may occur in the same IDLE cycle as the rsp pulse.
//   Legality (evaluated on latched regs):
//   - mask 11 is illegal.
//   - half with addr[0]!=0 is misaligned.
//   - word with addr[1:0]!=0 is misaligned.
//   - Illegal/misaligned: ACCESS drives mem_write=mem_read=0; response has rsp_err_o=1, rsp_rdata_o=0.
//   Word loads: sext is forced to 0 toward memory, because data_memory has no zero-extend word path.
//   Idle bus: when not in a legal ACCESS, mem_write=mem_read=0 and the other mem_* hold 0.
//   Requester rule: requester inputs may change freely once handshaken; only the latched copy is used.
// STRUCTURE
//   Shared header mem_defs.vh:
//   - MASK_BYTE=2'b00, MASK_HALF=2'b01, MASK_WORD=2'b10.
//   - State encodings ST_IDLE/ST_ACCESS.
//   Sub-module rr_arbiter2:
//   - Combinational 2-way grant from valid + pointer; pointer register kept in the parent.
//   Parent holds the FSM, request latch, legality check and response registers.
// TESTING
//   1. Reset, then port0 word store addr=0x10 wdata=0xDEADBEEF, then word load addr=0x10.
//      -> rsp_valid_o=01 each time; rdata=0xDEADBEEF, err=0.
//   2. Both ports valid every cycle from reset.
//      -> grants alternate 0,1,0,1; each response arrives 1 cycle after its handshake; ready=00 in ACCESS.
//   3. mem[4]=0x000000F0; byte load addr=0x04, sext=0 -> 0xFFFFFFF0; sext=1 -> 0x000000F0.
//   4. Port1 half load addr=0x03, then word store addr=0x06, then mask=11.
//      -> err=1, rdata=0 for all three; mem_write/mem_read never asserted; memory unchanged.
//   5. Assert rstn low mid-ACCESS of a store, before negedge.
//      -> mem_write drops immediately; no rsp pulse; location unchanged; state=IDLE after release.
//   6. Back-to-back: port0 handshakes in the cycle its previous rsp_valid is high.
//      -> accepted; the two responses are 2 cycles apart.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   MASK_*        maskmode encodings understood by data_memory
//   state_t       arbiter FSM states
//   access_legal  size/alignment check for a single request
package dmem_arbiter_pkg;

   localparam logic [1:0] MASK_BYTE = 2'b00;
   localparam logic [1:0] MASK_HALF = 2'b01;
   localparam logic [1:0] MASK_WORD = 2'b10;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   // A request is legal when its size is defined and its address is
   // naturally aligned to that size.
   function automatic logic access_legal(input logic [1:0] mask,
                                         input logic [1:0] addr_lo);
      logic legal;
      case (mask)
         MASK_BYTE: legal = 1'b1;
         MASK_HALF: legal = (addr_lo[0] == 1'b0);
         MASK_WORD: legal = (addr_lo == 2'b00);
         default:   legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant, purely combinational.
//   valid   in  2  requester valid bits
//   favour  in  1  port that wins when both are valid
//   grant   out 2  one-hot grant (or 00 when nothing is valid)
// The favour register lives in the parent so it only moves on a handshake.
module rr_arbiter2 (
   input  logic [1:0] valid,
   input  logic       favour,
   output logic [1:0] grant
);

   for (genvar gi = 0; gi < 2; gi++) begin : g_grant
      // A port wins if it is valid and either alone or currently favoured.
      assign grant[gi] = valid[gi] & (~valid[1-gi] | (favour == 1'(gi)));
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data_memory port between the core LSU (port 0) and the
// debug/loader (port 1). Each accepted request takes one registered ACCESS
// cycle followed by a one-cycle response pulse to its owner.
//   clk, rstn          clock, asynchronous active-low reset
//   req_*_i / req_ready_o   per-port valid/ready request channel
//   rsp_valid_o/err/rdata   registered response (rdata 0 for stores/errors)
//   mem_write .. write_data to data_memory (all registered), read_data back
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [1:0]                 req_valid_i,
   output logic [1:0]                 req_ready_o,
   input  logic [1:0]                 req_write_i,
   input  logic [1:0][1:0]            req_mask_i,
   input  logic [1:0]                 req_sext_i,
   input  logic [1:0][ADDR_WIDTH-1:0] req_addr_i,
   input  logic [1:0][DATA_WIDTH-1:0] req_wdata_i,
   output logic [1:0]                 rsp_valid_o,
   output logic                       rsp_err_o,
   output logic [DATA_WIDTH-1:0]      rsp_rdata_o,
   output logic                       mem_write,
   output logic                       mem_read,
   output logic [1:0]                 maskmode,
   output logic                       sext,
   output logic [ADDR_WIDTH-1:0]      address,
   output logic [DATA_WIDTH-1:0]      write_data,
   input  logic [DATA_WIDTH-1:0]      read_data
);

   state_t                  state_reg, state_next;
   logic                    favour_reg;
   logic [1:0]              grant;
   logic                    sel;
   logic                    sel_write, sel_sext, sel_legal;
   logic [1:0]              sel_mask;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_wdata;
   logic                    id_reg, err_reg;
   logic                    mem_write_reg, mem_read_reg, mem_sext_reg;
   logic [1:0]              mem_mask_reg;
   logic [ADDR_WIDTH-1:0]   mem_addr_reg;
   logic [DATA_WIDTH-1:0]   mem_wdata_reg;
   logic [1:0]              rsp_valid_reg;
   logic                    rsp_err_reg;
   logic [DATA_WIDTH-1:0]   rsp_rdata_reg;

   rr_arbiter2 u_rr (
      .valid  (req_valid_i),
      .favour (favour_reg),
      .grant  (grant)
   );

   // Winner's request fields; grant is one-hot so grant[1] is the port id.
   assign sel       = grant[1];
   assign sel_write = req_write_i[sel];
   assign sel_mask  = req_mask_i[sel];
   assign sel_sext  = req_sext_i[sel];
   assign sel_addr  = req_addr_i[sel];
   assign sel_wdata = req_wdata_i[sel];
   assign sel_legal = access_legal(sel_mask, sel_addr[1:0]);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      req_ready_o = 2'b00;
      case (state_reg)
         ST_IDLE: begin
            // Reset holds every output low, including the combinational ready.
            if (rstn) begin
               req_ready_o = grant;
            end
            if (|grant) begin
               state_next = ST_ACCESS;
            end
         end
         ST_ACCESS: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Request latch and memory-side registers. The mem_* registers are loaded
   // at the handshake only for legal requests, so an illegal ACCESS and the
   // idle bus both present all zeros to data_memory.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         favour_reg    <= 1'b0;
         id_reg        <= 1'b0;
         err_reg       <= 1'b0;
         mem_write_reg <= 1'b0;
         mem_read_reg  <= 1'b0;
         mem_sext_reg  <= 1'b0;
         mem_mask_reg  <= '0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         rsp_valid_reg <= '0;
         rsp_err_reg   <= 1'b0;
         rsp_rdata_reg <= '0;
      end else begin
         rsp_valid_reg <= 2'b00;
         if (state_reg == ST_IDLE && (|grant)) begin
            favour_reg <= ~sel;
            id_reg     <= sel;
            err_reg    <= ~sel_legal;
            if (sel_legal) begin
               mem_write_reg <= sel_write;
               mem_read_reg  <= ~sel_write;
               mem_mask_reg  <= sel_mask;
               // data_memory has no zero-extend word path; word sext must be 0.
               mem_sext_reg  <= (sel_mask == MASK_WORD) ? 1'b0 : sel_sext;
               mem_addr_reg  <= sel_addr;
               mem_wdata_reg <= sel_wdata;
            end
         end else if (state_reg == ST_ACCESS) begin
            rsp_valid_reg[id_reg] <= 1'b1;
            rsp_err_reg           <= err_reg;
            rsp_rdata_reg         <= mem_read_reg ? read_data : '0;
            mem_write_reg         <= 1'b0;
            mem_read_reg          <= 1'b0;
            mem_sext_reg          <= 1'b0;
            mem_mask_reg          <= '0;
            mem_addr_reg          <= '0;
            mem_wdata_reg         <= '0;
         end
      end
   end

   assign rsp_valid_o = rsp_valid_reg;
   assign rsp_err_o   = rsp_err_reg;
   assign rsp_rdata_o = rsp_rdata_reg;
   assign mem_write   = mem_write_reg;
   assign mem_read    = mem_read_reg;
   assign maskmode    = mem_mask_reg;
   assign sext        = mem_sext_reg;
   assign address     = mem_addr_reg;
   assign write_data  = mem_wdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic,
// checked each cycle against a transaction-level model of the arbiter and
// a byte-array model of data_memory.
module tb_dmem_arbiter;

   localparam int DW = 32;
   localparam int AW = 32;

   logic                clk = 1'b0;
   logic                rstn = 1'b0;
   logic [1:0]          req_valid_i = '0;
   logic [1:0]          req_ready_o;
   logic [1:0]          req_write_i = '0;
   logic [1:0][1:0]     req_mask_i = '0;
   logic [1:0]          req_sext_i = '0;
   logic [1:0][AW-1:0]  req_addr_i = '0;
   logic [1:0][DW-1:0]  req_wdata_i = '0;
   logic [1:0]          rsp_valid_o;
   logic                rsp_err_o;
   logic [DW-1:0]       rsp_rdata_o;
   logic                mem_write, mem_read, sext;
   logic [1:0]          maskmode;
   logic [AW-1:0]       address;
   logic [DW-1:0]       write_data;
   logic [DW-1:0]       read_data;

   always #5 clk = ~clk;

   dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_write_i(req_write_i), .req_mask_i(req_mask_i),
      .req_sext_i(req_sext_i), .req_addr_i(req_addr_i),
      .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
      .mem_write(mem_write), .mem_read(mem_read), .maskmode(maskmode),
      .sext(sext), .address(address), .write_data(write_data),
      .read_data(read_data)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- data_memory stand-in (negedge write, comb read) -------
   logic [7:0] dmem [64];
   logic [5:0] ea0, ea1, ea2, ea3;
   assign ea0 = address[5:0];
   assign ea1 = ea0 + 6'd1;
   assign ea2 = ea0 + 6'd2;
   assign ea3 = ea0 + 6'd3;

   always_comb begin
      case (maskmode)
         2'b00:   read_data = sext ? {24'h0, dmem[ea0]} : {{24{dmem[ea0][7]}}, dmem[ea0]};
         2'b01:   read_data = sext ? {16'h0, dmem[ea1], dmem[ea0]}
                                   : {{16{dmem[ea1][7]}}, dmem[ea1], dmem[ea0]};
         default: read_data = {dmem[ea3], dmem[ea2], dmem[ea1], dmem[ea0]};
      endcase
   end

   always @(negedge clk) begin
      if (mem_write) begin
         dmem[ea0] = write_data[7:0];
         if (maskmode != 2'b00) dmem[ea1] = write_data[15:8];
         if (maskmode == 2'b10) begin
            dmem[ea2] = write_data[23:16];
            dmem[ea3] = write_data[31:24];
         end
      end
   end

   // ---------------- reference model ---------------------------------------
   logic [7:0]  m_mem [64];
   logic        m_busy = 1'b0;
   logic        m_last = 1'b1;      // last granted port; 1 so port 0 wins first
   logic        m_rsp_due = 1'b0;
   logic        m_rsp_port = 1'b0;
   logic        m_rsp_err = 1'b0;
   logic [31:0] m_rsp_rdata = '0;
   logic        c_port, c_write, c_sext;
   logic [1:0]  c_mask;
   logic [31:0] c_addr, c_wdata;
   int          cyc = 0;
   int          last_rsp0 = 0;
   int          gap0 = 0;
   int          hs_cnt [2];

   function automatic logic model_legal(input logic [1:0] m, input logic [31:0] a);
      int sz;
      if (m == 2'b11) return 1'b0;
      sz = 1 << m;
      return (a % sz) == 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] m, input logic s,
                                              input logic [31:0] a);
      int n;
      logic [31:0] v;
      n = 1 << m;
      v = 0;
      for (int i = 0; i < n; i++) v = v | (32'(m_mem[(a + i) % 64]) << (8 * i));
      if (!s && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   task automatic model_store(input logic [1:0] m, input logic [31:0] a, input logic [31:0] d);
      int n;
      n = 1 << m;
      for (int i = 0; i < n; i++) m_mem[(a + i) % 64] = 8'((d >> (8 * i)) & 32'hFF);
   endtask

   always @(negedge clk) begin
      logic        legal;
      logic        win;
      logic [1:0]  exp_rv, exp_rdy;
      cyc++;
      if (!rstn) begin
         m_busy = 1'b0;
         m_last = 1'b1;
         m_rsp_due = 1'b0;
      end else begin
         exp_rv = m_rsp_due ? (2'b01 << m_rsp_port) : 2'b00;
         chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_rv));
         if (m_rsp_due) begin
            chk("rsp_err", 32'(rsp_err_o), 32'(m_rsp_err));
            chk("rsp_rdata", rsp_rdata_o, m_rsp_rdata);
         end
         if (rsp_valid_o[0]) begin
            gap0 = cyc - last_rsp0;
            last_rsp0 = cyc;
         end
         m_rsp_due = 1'b0;
         if (m_busy) begin
            legal = model_legal(c_mask, c_addr);
            chk("ready_access", 32'(req_ready_o), 32'h0);
            chk("mem_write", 32'(mem_write), 32'(legal && c_write));
            chk("mem_read", 32'(mem_read), 32'(legal && !c_write));
            if (legal) begin
               chk("address", address, c_addr);
               chk("maskmode", 32'(maskmode), 32'(c_mask));
               chk("sext", 32'(sext), 32'((c_mask == 2'b10) ? 1'b0 : c_sext));
               if (c_write) chk("write_data", write_data, c_wdata);
            end
            m_rsp_due   = 1'b1;
            m_rsp_port  = c_port;
            m_rsp_err   = !legal;
            m_rsp_rdata = 0;
            if (legal && c_write) model_store(c_mask, c_addr, c_wdata);
            else if (legal) m_rsp_rdata = model_load(c_mask, c_sext, c_addr);
            m_busy = 1'b0;
         end else begin
            win = (req_valid_i == 2'b11) ? !m_last : req_valid_i[1];
            exp_rdy = (req_valid_i == 2'b00) ? 2'b00 : (2'b01 << win);
            chk("ready", 32'(req_ready_o), 32'(exp_rdy));
            chk("idle_mem_write", 32'(mem_write), 32'h0);
            chk("idle_mem_read", 32'(mem_read), 32'h0);
            chk("idle_address", address, 32'h0);
            if (req_valid_i != 2'b00) begin
               c_port  = win;
               c_write = req_write_i[win];
               c_mask  = req_mask_i[win];
               c_sext  = req_sext_i[win];
               c_addr  = req_addr_i[win];
               c_wdata = req_wdata_i[win];
               hs_cnt[win]++;
               m_last  = win;
               m_busy  = 1'b1;
            end
         end
      end
   end

   // One request on port p; returns its response. Entered and left at
   // posedge+1 so inputs never change near a sampling point.
   task automatic do_req(input int p, input logic w, input logic [1:0] m, input logic s,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic ok, output logic err, output logic [31:0] rd);
      logic got;
      got = 1'b0;
      ok = 1'b0; err = 1'bx; rd = 'x;
      req_write_i[p] = w; req_mask_i[p] = m; req_sext_i[p] = s;
      req_addr_i[p] = a; req_wdata_i[p] = d; req_valid_i[p] = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (req_ready_o[p]) got = 1'b1;
      end
      @(posedge clk); #1;
      req_valid_i[p] = 1'b0;
      if (got) begin
         for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid_o[p]) begin
               ok = 1'b1; err = rsp_err_o; rd = rsp_rdata_o;
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic req_chk(input string tag, input int p, input logic w, input logic [1:0] m,
                          input logic s, input logic [31:0] a, input logic [31:0] d,
                          input logic exp_err, input logic [31:0] exp_rd);
      logic ok, err;
      logic [31:0] rd;
      do_req(p, w, m, s, a, d, ok, err, rd);
      chk({tag, "_done"}, 32'(ok), 32'h1);
      chk({tag, "_err"}, 32'(err), 32'(exp_err));
      chk({tag, "_rdata"}, rd, exp_rd);
      $display("req %s: port=%0d write=%0d mask=%0d addr=%h -> err=%0d rdata=%h",
               tag, p, w, m, a, err, rd);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int diffs;
      for (int i = 0; i < 64; i++) begin
         dmem[i] = 8'h00;
         m_mem[i] = 8'h00;
      end
      hs_cnt[0] = 0; hs_cnt[1] = 0;

      // Reset: every output low even with both requesters valid.
      req_valid_i = 2'b11;
      #2;
      chk("rst_ready", 32'(req_ready_o), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
      chk("rst_mem_write", 32'(mem_write), 32'h0);
      chk("rst_mem_read", 32'(mem_read), 32'h0);
      chk("rst_rdata", rsp_rdata_o, 32'h0);
      req_valid_i = 2'b00;
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;

      // Word store then load on port 0.
      req_chk("st_word", 0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
      req_chk("ld_word", 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

      // Sign- versus zero-extended byte load.
      req_chk("st_f0", 0, 1'b1, 2'b10, 1'b0, 32'h04, 32'h000000F0, 1'b0, 32'h0);
      req_chk("ld_byte_s", 0, 1'b0, 2'b00, 1'b0, 32'h04, 32'h0, 1'b0, 32'hFFFFFFF0);
      req_chk("ld_byte_z", 0, 1'b0, 2'b00, 1'b1, 32'h04, 32'h0, 1'b0, 32'h000000F0);

      // Rejected requests on port 1 leave memory untouched.
      req_chk("mis_half", 1, 1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 1'b1, 32'h0);
      req_chk("mis_word", 1, 1'b1, 2'b10, 1'b0, 32'h06, 32'hAAAAAAAA, 1'b1, 32'h0);
      req_chk("bad_mask", 1, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1'b1, 32'h0);
      req_chk("keep_04", 1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b0, 32'h000000F0);
      req_chk("keep_08", 1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0, 32'h0);

      // Port 0 held valid: a handshake every 2 cycles, responses 2 apart.
      req_write_i[0] = 1'b0; req_mask_i[0] = 2'b10; req_addr_i[0] = 32'h10;
      req_valid_i[0] = 1'b1;
      hs_cnt[0] = 0; hs_cnt[1] = 0;
      repeat (8) @(negedge clk);
      #1;
      req_valid_i[0] = 1'b0;
      chk("b2b_handshakes", 32'(hs_cnt[0]), 32'd4);
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_rsp_gap", 32'(gap0), 32'd2);
      $display("b2b: handshakes=%0d rsp_gap=%0d", hs_cnt[0], gap0);

      // Both ports valid from reset: grants alternate 0,1,0,1.
      rstn = 1'b0;
      req_write_i = 2'b00; req_mask_i = '{2'b10, 2'b10};
      req_addr_i[0] = 32'h10; req_addr_i[1] = 32'h04;
      req_valid_i = 2'b11;
      @(posedge clk); #1;
      rstn = 1'b1;
      hs_cnt[0] = 0; hs_cnt[1] = 0;
      repeat (8) @(negedge clk);
      #1;
      req_valid_i = 2'b00;
      chk("alt_grants0", 32'(hs_cnt[0]), 32'd2);
      chk("alt_grants1", 32'(hs_cnt[1]), 32'd2);
      $display("alternate: grants0=%0d grants1=%0d", hs_cnt[0], hs_cnt[1]);
      repeat (3) @(posedge clk);
      #1;

      // Reset mid-ACCESS of a store: strobe drops at once, store is lost.
      req_write_i[0] = 1'b1; req_mask_i[0] = 2'b10; req_sext_i[0] = 1'b0;
      req_addr_i[0] = 32'h30; req_wdata_i[0] = 32'h12345678;
      req_valid_i[0] = 1'b1;
      @(negedge clk);
      chk("rst_acc_grant", 32'(req_ready_o), 32'h1);
      @(posedge clk); #1;
      req_valid_i[0] = 1'b0;
      chk("rst_acc_strobe", 32'(mem_write), 32'h1);
      rstn = 1'b0;
      #1;
      chk("rst_acc_drop", 32'(mem_write), 32'h0);
      chk("rst_acc_rsp", 32'(rsp_valid_o), 32'h0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      $display("reset-in-access: store dropped");
      req_chk("after_rst", 0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0);

      // Random traffic on both ports, checked by the model every cycle.
      repeat (400) begin
         @(posedge clk); #1;
         for (int p = 0; p < 2; p++) begin
            int r;
            r = $urandom_range(0, 9);
            req_valid_i[p] = ($urandom_range(0, 3) != 0);
            req_write_i[p] = $urandom_range(0, 1) == 1;
            req_mask_i[p]  = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            req_sext_i[p]  = $urandom_range(0, 1) == 1;
            req_addr_i[p]  = 32'($urandom_range(0, 63));
            req_wdata_i[p] = $urandom;
         end
      end
      @(posedge clk); #1;
      req_valid_i = 2'b00;
      repeat (4) @(posedge clk);
      #1;

      diffs = 0;
      for (int i = 0; i < 64; i++) if (dmem[i] !== m_mem[i]) diffs++;
      chk("mem_final", 32'(diffs), 32'd0);
      $display("random: memory bytes differing=%0d", diffs);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
